// File: rtl/tlb_op_unit.sv
// TLB operation sequencer: runs TLBP/TLBR/TLBWI/TLBWR against the MMU array
// and keeps the CP0 Random register counting down towards Wired.
package tlb_pkg;

   typedef logic [5:0] tlb_index_t;

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      logic [19:0] pfn0;
      logic [4:0]  flags0;
      logic [19:0] pfn1;
      logic [4:0]  flags1;
   } tlb_entry_t;

   typedef enum logic [1:0] {
      OP_TLBP  = 2'd0,
      OP_TLBR  = 2'd1,
      OP_TLBWI = 2'd2,
      OP_TLBWR = 2'd3
   } tlb_op_e;

endpackage

module tlb_op_unit
   import tlb_pkg::*;
#(
   parameter int TLB_ENTRIES = 16,
   parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_valid,
   input  logic [1:0]       op,
   output logic             op_ready,
   output logic             done,
   input  logic [31:0]      cp0_index,
   input  logic [31:0]      cp0_entry_hi,
   input  logic [IDX_W-1:0] cp0_wired,
   input  logic             wired_we,
   input  tlb_entry_t       entry_wdata,
   output tlb_index_t       tlbrw_index,
   output logic             tlbrw_we,
   output tlb_entry_t       tlbrw_wdata,
   input  tlb_entry_t       tlbrw_rdata,
   output logic [31:0]      tlbp_entry_hi,
   input  logic [31:0]      tlbp_index,
   output logic             index_we,
   output logic [31:0]      index_wdata,
   output logic             entry_we,
   output tlb_entry_t       entry_rdata,
   output logic [IDX_W-1:0] random
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_ENTRIES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_WAIT,
      S_RESP
   } state_e;

   state_e           state, state_next;
   tlb_op_e          op_q;
   logic [IDX_W-1:0] index_q;
   logic [IDX_W-1:0] random_q;
   logic [31:0]      entry_hi_q;
   tlb_entry_t       wdata_q;
   logic             accept;
   logic             is_write;

   // Upper Index bits (including the probe-fail flag) have no meaning here.
   logic unused_index_hi;
   assign unused_index_hi = ^cp0_index[31:IDX_W];

   assign accept   = op_valid && (state == S_IDLE);
   assign is_write = (op_q == OP_TLBWI) || (op_q == OP_TLBWR);

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Wired is compared every cycle, so raising Wired above Random wraps at once.
   always_ff @(posedge clk) begin
      if (reset)                 random <= LAST_IDX;
      else if (wired_we)         random <= LAST_IDX;
      else if (random <= cp0_wired) random <= LAST_IDX;
      else                       random <= random - IDX_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q       <= OP_TLBP;
         index_q    <= '0;
         random_q   <= '0;
         entry_hi_q <= '0;
         wdata_q    <= '0;
      end else if (accept) begin
         op_q       <= tlb_op_e'(op);
         index_q    <= cp0_index[IDX_W-1:0];
         random_q   <= random;
         entry_hi_q <= cp0_entry_hi;
         wdata_q    <= entry_wdata;
      end
   end

   // Array read/probe data is valid during WAIT, one cycle after presentation.
   always_ff @(posedge clk) begin
      if (reset) begin
         index_wdata <= '0;
         entry_rdata <= '0;
      end else if (state == S_WAIT) begin
         if (op_q == OP_TLBP) index_wdata <= tlbp_index;
         if (op_q == OP_TLBR) entry_rdata <= tlbrw_rdata;
      end
   end

   always_comb begin
      tlbrw_index = '0;
      tlbrw_index[IDX_W-1:0] = (op_q == OP_TLBWR) ? random_q : index_q;
   end

   assign tlbp_entry_hi = entry_hi_q;
   assign tlbrw_wdata   = wdata_q;

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_next = state;
      op_ready   = 1'b0;
      done       = 1'b0;
      tlbrw_we   = 1'b0;
      index_we   = 1'b0;
      entry_we   = 1'b0;
      case (state)
         S_IDLE: begin
            op_ready = 1'b1;
            if (op_valid) state_next = S_EXEC;
         end
         S_EXEC: begin
            tlbrw_we   = is_write;
            state_next = is_write ? S_RESP : S_WAIT;
         end
         S_WAIT: state_next = S_RESP;
         S_RESP: begin
            done       = 1'b1;
            index_we   = (op_q == OP_TLBP);
            entry_we   = (op_q == OP_TLBR);
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_tlb_op_unit.sv
// Directed bench for tlb_op_unit with a small registered-read TLB array model.
module tb_tlb_op_unit;
   import tlb_pkg::*;

   localparam tlb_entry_t E1 = '{vpn2: 19'h1_2345, asid: 8'hA1, g: 1'b1,
                                 pfn0: 20'h0_0100, flags0: 5'h1F,
                                 pfn1: 20'h0_0101, flags1: 5'h17};
   localparam tlb_entry_t E2 = '{vpn2: 19'h5_4321, asid: 8'h3C, g: 1'b0,
                                 pfn0: 20'hA_BCDE, flags0: 5'h0B,
                                 pfn1: 20'hF_0F0F, flags1: 5'h15};
   localparam tlb_entry_t E3 = '{vpn2: 19'h0_0333, asid: 8'h33, g: 1'b1,
                                 pfn0: 20'h3_3330, flags0: 5'h03,
                                 pfn1: 20'h3_3331, flags1: 5'h1C};

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic [1:0]  op;
   logic        op_ready, done;
   logic [31:0] cp0_index, cp0_entry_hi;
   logic [3:0]  cp0_wired;
   logic        wired_we;
   tlb_entry_t  entry_wdata;
   tlb_index_t  tlbrw_index;
   logic        tlbrw_we;
   tlb_entry_t  tlbrw_wdata, tlbrw_rdata;
   logic [31:0] tlbp_entry_hi, tlbp_index;
   logic        index_we, entry_we;
   logic [31:0] index_wdata;
   tlb_entry_t  entry_rdata;
   logic [3:0]  random;

   int checks = 0;
   int errors = 0;

   tlb_op_unit #(.TLB_ENTRIES(16)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
      .op_ready(op_ready), .done(done), .cp0_index(cp0_index),
      .cp0_entry_hi(cp0_entry_hi), .cp0_wired(cp0_wired), .wired_we(wired_we),
      .entry_wdata(entry_wdata), .tlbrw_index(tlbrw_index), .tlbrw_we(tlbrw_we),
      .tlbrw_wdata(tlbrw_wdata), .tlbrw_rdata(tlbrw_rdata),
      .tlbp_entry_hi(tlbp_entry_hi), .tlbp_index(tlbp_index),
      .index_we(index_we), .index_wdata(index_wdata), .entry_we(entry_we),
      .entry_rdata(entry_rdata), .random(random)
   );

   always #5 clk = ~clk;

   // TLB array: entry 3 preloaded during reset, read data one cycle late.
   tlb_entry_t tlb_mem [16];
   always @(posedge clk) begin
      if (reset) tlb_mem[3] <= E3;
      else if (tlbrw_we) tlb_mem[tlbrw_index[3:0]] <= tlbrw_wdata;
      tlbrw_rdata <= tlb_mem[tlbrw_index[3:0]];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [3:0] rand_seq [13];

   initial begin
      rand_seq = '{4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8,
                   4'd7, 4'd6, 4'd5, 4'd4, 4'd15, 4'd14};

      // Reset with op_valid and wired_we also high: reset must win.
      reset = 1'b1; op_valid = 1'b1; op = 2'd2; wired_we = 1'b1;
      cp0_wired = 4'd4; cp0_index = 32'd5; cp0_entry_hi = 32'h0;
      entry_wdata = E1; tlbp_index = 32'h8000_0000;
      step(); step();
      check("rst_op_ready", op_ready, 1'b1);
      check("rst_done", done, 1'b0);
      check("rst_tlbrw_we", tlbrw_we, 1'b0);
      check("rst_index_we", index_we, 1'b0);
      check("rst_entry_we", entry_we, 1'b0);
      check("rst_index_wdata", index_wdata, 32'h0);
      check("rst_entry_rdata", entry_rdata, 78'h0);
      check("rst_tlbrw_index", tlbrw_index, 6'd0);
      check("rst_tlbp_entry_hi", tlbp_entry_hi, 32'h0);
      check("rst_random", random, 4'd15);

      reset = 1'b0; op_valid = 1'b0; wired_we = 1'b0;
      for (int k = 0; k < 13; k++) begin
         step();
         check("rand_seq", random, rand_seq[k]);
      end

      repeat (5) step();
      check("rand_pre_wired_we", random, 4'd9);
      wired_we = 1'b1;
      step();
      check("rand_wired_we", random, 4'd15);
      wired_we = 1'b0;
      step();
      check("rand_after_wired_we", random, 4'd14);

      // TLBWR accepted while random = 7.
      repeat (7) step();
      check("rand_pre_tlbwr", random, 4'd7);
      op_valid = 1'b1; op = 2'd3; entry_wdata = E1; cp0_index = 32'd2;
      step();
      op_valid = 1'b0;
      check("wr_exec_ready", op_ready, 1'b0);
      check("wr_exec_we", tlbrw_we, 1'b1);
      check("wr_exec_index", tlbrw_index, 6'd7);
      check("wr_exec_wdata", tlbrw_wdata, E1);
      check("wr_exec_done", done, 1'b0);
      step();
      check("wr_resp_done", done, 1'b1);
      check("wr_resp_we", tlbrw_we, 1'b0);
      check("wr_resp_index_we", index_we, 1'b0);
      check("wr_resp_entry_we", entry_we, 1'b0);
      step();
      check("wr_idle_ready", op_ready, 1'b1);
      check("wr_idle_done", done, 1'b0);

      // TLBWI index 5 (upper bits ignored); operands change after accept.
      op_valid = 1'b1; op = 2'd2; cp0_index = 32'hFFFF_FFF5; entry_wdata = E2;
      step();
      op_valid = 1'b0; cp0_index = 32'd9; entry_wdata = E3;
      check("wi_exec_index", tlbrw_index, 6'd5);
      check("wi_exec_we", tlbrw_we, 1'b1);
      check("wi_exec_wdata", tlbrw_wdata, E2);
      step();
      check("wi_resp_done", done, 1'b1);
      check("wi_resp_we", tlbrw_we, 1'b0);
      check("wi_resp_index_we", index_we, 1'b0);
      check("wi_resp_entry_we", entry_we, 1'b0);
      check("wi_resp_wdata_held", tlbrw_wdata, E2);
      step();

      // TLBP with a probe miss.
      op_valid = 1'b1; op = 2'd0; cp0_entry_hi = 32'h1234_5000;
      step();
      op_valid = 1'b0; cp0_entry_hi = 32'hDEAD_0000;
      check("p_exec_hi", tlbp_entry_hi, 32'h1234_5000);
      check("p_exec_we", tlbrw_we, 1'b0);
      check("p_exec_done", done, 1'b0);
      step();
      check("p_wait_done", done, 1'b0);
      check("p_wait_index_we", index_we, 1'b0);
      check("p_wait_hi", tlbp_entry_hi, 32'h1234_5000);
      step();
      check("p_resp_index_we", index_we, 1'b1);
      check("p_resp_done", done, 1'b1);
      check("p_resp_index_wdata", index_wdata, 32'h8000_0000);
      check("p_resp_entry_we", entry_we, 1'b0);
      check("p_resp_tlbrw_we", tlbrw_we, 1'b0);
      step();
      check("p_idle_index_we", index_we, 1'b0);
      check("p_idle_index_wdata", index_wdata, 32'h8000_0000);

      // TLBR index 3 with op_valid held; second TLBR (index 5) back-to-back.
      op_valid = 1'b1; op = 2'd1; cp0_index = 32'd3;
      step();
      check("r_exec_ready", op_ready, 1'b0);
      check("r_exec_index", tlbrw_index, 6'd3);
      check("r_exec_we", tlbrw_we, 1'b0);
      step();
      check("r_wait_ready", op_ready, 1'b0);
      check("r_wait_done", done, 1'b0);
      step();
      check("r_resp_entry_we", entry_we, 1'b1);
      check("r_resp_done", done, 1'b1);
      check("r_resp_entry_rdata", entry_rdata, E3);
      check("r_resp_index_we", index_we, 1'b0);
      cp0_index = 32'd5;
      step();
      check("r_idle_ready", op_ready, 1'b1);
      check("r_idle_done", done, 1'b0);
      check("r_idle_entry_we", entry_we, 1'b0);
      step();
      op_valid = 1'b0;
      check("r2_exec_ready", op_ready, 1'b0);
      check("r2_exec_index", tlbrw_index, 6'd5);
      step();
      step();
      check("r2_resp_entry_we", entry_we, 1'b1);
      check("r2_resp_done", done, 1'b1);
      check("r2_resp_entry_rdata", entry_rdata, E2);
      check("r2_resp_index_wdata_held", index_wdata, 32'h8000_0000);
      step();

      // Reset while a TLBR sits in WAIT.
      op_valid = 1'b1; op = 2'd1; cp0_index = 32'd7;
      step();
      op_valid = 1'b0;
      step();
      check("rw_wait_done", done, 1'b0);
      reset = 1'b1;
      step();
      check("rw_rst_ready", op_ready, 1'b1);
      check("rw_rst_done", done, 1'b0);
      check("rw_rst_entry_we", entry_we, 1'b0);
      check("rw_rst_random", random, 4'd15);
      check("rw_rst_entry_rdata", entry_rdata, 78'h0);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("rw_post_done", done, 1'b0);
         check("rw_post_entry_we", entry_we, 1'b0);
      end

      // Wired at the top entry pins random.
      cp0_wired = 4'd15;
      step(); step();
      check("wired_max_a", random, 4'd15);
      step();
      check("wired_max_b", random, 4'd15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tlb_op_unit.md
TLB_OP_UNIT -- requirements
Module: tlb_op_unit

Interface
REQ-001 SHALL have parameter TLB_ENTRIES, default 16, number of TLB entries (power of 2, 4..64).
REQ-002 SHALL have parameter IDX_W, default $clog2(TLB_ENTRIES), TLB index width.
REQ-003 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports op_valid  in  1 and op  in  2  request and opcode: 0=TLBP, 1=TLBR, 2=TLBWI, 3=TLBWR.
REQ-006 SHALL have port op_ready  out  1  block can accept a request.
REQ-007 SHALL have port done  out  1  single-cycle completion pulse.
REQ-008 SHALL have ports cp0_index  in  32, cp0_entry_hi  in  32, cp0_wired  in  IDX_W, wired_we  in  1, and entry_wdata  in  tlb_entry_t (CP0 state).
REQ-009 SHALL have MMU-side ports tlbrw_index  out  tlb_index_t, tlbrw_we  out  1, tlbrw_wdata  out  tlb_entry_t, tlbrw_rdata  in  tlb_entry_t, tlbp_entry_hi  out  32, tlbp_index  in  32.
REQ-010 SHALL have result ports index_we  out  1, index_wdata  out  32, entry_we  out  1, entry_rdata  out  tlb_entry_t, random  out  IDX_W.

Function
REQ-011 SHALL implement FSM states IDLE, EXEC, WAIT, RESP; op_ready=1 only in IDLE.
REQ-012 SHALL accept a request on a cycle with op_valid & op_ready, capturing op, cp0_index[IDX_W-1:0], cp0_entry_hi, entry_wdata and the current random value, and moving to EXEC.
REQ-013 SHALL ignore op_valid outside IDLE; captured operands SHALL not change until return to IDLE.
REQ-014 In EXEC, SHALL drive tlbrw_index = captured random for TLBWR, else captured index; tlbp_entry_hi = captured entry_hi; tlbrw_wdata = captured entry_wdata.
REQ-015 In EXEC, SHALL assert tlbrw_we for exactly one cycle for TLBWI/TLBWR and then go to RESP; TLBP/TLBR SHALL go to WAIT with tlbrw_we=0.
REQ-016 SHALL hold tlbrw_index and tlbp_entry_hi stable through EXEC and WAIT (TLB read/probe data valid one cycle after presentation).
REQ-017 In WAIT, SHALL register tlbp_index (TLBP) or tlbrw_rdata (TLBR) into index_wdata / entry_rdata and go to RESP.
REQ-018 In RESP, SHALL pulse done; SHALL pulse index_we for TLBP and entry_we for TLBR; neither for writes; then go to IDLE.
REQ-019 Latency accept→done: writes 2 cycles, TLBP/TLBR 3 cycles; back-to-back op accepted the cycle after done.
REQ-020 index_wdata SHALL be tlbp_index passed unmodified (bit 31 = probe fail).
REQ-021 random SHALL update every cycle: next = TLB_ENTRIES-1 if random <= cp0_wired, else random-1.
REQ-022 wired_we=1 SHALL force random to TLB_ENTRIES-1 next cycle, overriding REQ-021.
REQ-023 If cp0_wired >= TLB_ENTRIES-1, random SHALL stay TLB_ENTRIES-1.
REQ-024 tlbrw_we, index_we, entry_we, done SHALL be 0 in every state except where REQ-015/018 assert them.
REQ-025 index_wdata/entry_rdata SHALL hold their last value until overwritten.

Reset
REQ-026 On reset, SHALL enter IDLE in the next cycle, abandoning any operation; no tlbrw_we, done, index_we or entry_we pulse SHALL follow.
REQ-027 Reset values: op_ready=1, done=0, tlbrw_we=0, index_we=0, entry_we=0, index_wdata=0, entry_rdata='0, tlbrw_index=0, tlbp_entry_hi=0, random=TLB_ENTRIES-1.
REQ-028 Reset SHALL dominate op_valid and wired_we in the same cycle.

Verification
REQ-029 TLBWI, cp0_index=5 → EXEC: tlbrw_index=5, tlbrw_we=1 one cycle, wdata=entry_wdata; done 2 cycles after accept; no index_we/entry_we.
REQ-030 TLBP, TLB returns tlbp_index=0x8000_0000 → index_we & done in same cycle, 3 cycles after accept, index_wdata=0x8000_0000; tlbrw_we stays 0.
REQ-031 TLBR index 3, TLB entry 3 preloaded → entry_we & done 3 cycles after accept, entry_rdata = entry 3; op_valid held high during op → next op accepted only in IDLE.
REQ-032 Random, wired=4, 16 entries: from reset sequence 15,14,…,4,15 (period 12); wired_we at random=9 → 15 next cycle; TLBWR accepted when random=7 → tlbrw_index=7.
REQ-033 Reset in WAIT of TLBR → IDLE next cycle, op_ready=1, entry_we and done never pulse, random=15.
